// File: rtl/spi_slave.sv
`timescale 1ns/1ps
// spi_slave: SPI peripheral with 2-flop oversampling of sck/ss/mosi, single-entry
// tx/rx buffers and a host bus compatible with spi_master.
module spi_slave #(
    parameter int WORD_LEN = 8
) (
    input  logic                clk,
    input  logic                rst,
    inout  wire  [WORD_LEN-1:0] data,
    input  logic                wr,
    input  logic                rd,
    output logic                buffempty,
    output logic                charreceived,
    output logic                senderr,
    input  logic                res_senderr,
    output logic                overrun,
    input  logic                res_overrun,
    input  logic                lsbfirst,
    input  logic [1:0]          mode,
    input  logic                sck,
    input  logic                mosi,
    output wire                 miso,
    input  logic                ss
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t state_r;
    state_t state_nx_s;

    logic sck_m_r, sck_s_r, sck_d_r;
    logic ss_m_r, ss_s_r;
    logic mosi_m_r, mosi_s_r;

    logic [4:0]          bit_cnt_r;
    logic [WORD_LEN-1:0] tx_sh_r;
    logic [WORD_LEN-1:0] rx_sh_r;
    logic [WORD_LEN-1:0] tx_buf_r;
    logic [WORD_LEN-1:0] rx_buf_r;
    logic                miso_r;
    logic                buffempty_r;
    logic                charreceived_r;
    logic                senderr_r;
    logic                overrun_r;

    logic                cpol_s;
    logic                cpha_s;
    logic                lead_s;
    logic                trail_s;
    logic                load_s;
    logic                take_s;
    logic                sample_s;
    logic                shift_s;
    logic                word_done_s;
    logic                wr_ok_s;
    logic                wr_err_s;
    logic [WORD_LEN-1:0] load_word_s;
    logic [WORD_LEN-1:0] rx_next_s;

    // Bit that leaves the shift register next, according to bit order.
    function automatic logic out_bit(input logic [WORD_LEN-1:0] w, input logic lsb);
        return lsb ? w[0] : w[WORD_LEN-1];
    endfunction

    // Shift register after one bit has been presented; vacated bits fill with ones.
    function automatic logic [WORD_LEN-1:0] out_shift(input logic [WORD_LEN-1:0] w,
                                                      input logic lsb);
        return lsb ? {1'b1, w[WORD_LEN-1:1]} : {w[WORD_LEN-2:0], 1'b1};
    endfunction

    // Receive shift: MSB-first enters at bit0, LSB-first enters at the top.
    function automatic logic [WORD_LEN-1:0] in_shift(input logic [WORD_LEN-1:0] w,
                                                     input logic b, input logic lsb);
        return lsb ? {b, w[WORD_LEN-1:1]} : {w[WORD_LEN-2:0], b};
    endfunction

    assign buffempty    = buffempty_r;
    assign charreceived = charreceived_r;
    assign senderr      = senderr_r;
    assign overrun      = overrun_r;
    assign data         = rd ? rx_buf_r : {WORD_LEN{1'bz}};
    assign miso         = (ss || (state_r == ST_IDLE)) ? 1'bz : miso_r;

    // Edge qualification and host-side strobes.
    always_comb begin
        cpol_s      = mode[1];
        cpha_s      = mode[0];
        lead_s      = (sck_d_r == cpol_s) && (sck_s_r != cpol_s);
        trail_s     = (sck_d_r != cpol_s) && (sck_s_r == cpol_s);
        load_s      = (state_r == ST_LOAD);
        take_s      = load_s && !buffempty_r;
        load_word_s = buffempty_r ? {WORD_LEN{1'b1}} : tx_buf_r;
        sample_s    = (state_r == ST_SHIFT) && !ss_s_r && (cpha_s ? trail_s : lead_s);
        // With CPHA=0 the trailing edge right after a word's last sample belongs to
        // that word; the next word's first bit is already out from LOAD.
        shift_s     = (state_r == ST_SHIFT) && !ss_s_r && (cpha_s ? lead_s : trail_s)
                      && (cpha_s || (bit_cnt_r != 5'd0));
        word_done_s = sample_s && (bit_cnt_r == 5'(WORD_LEN - 1));
        rx_next_s   = in_shift(rx_sh_r, mosi_s_r, lsbfirst);
        wr_ok_s     = wr && (buffempty_r || take_s);
        wr_err_s    = wr && !wr_ok_s;
    end

    // Two-flop synchronizers plus the delayed sck copy used for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_m_r  <= mode[1];
            sck_s_r  <= mode[1];
            sck_d_r  <= mode[1];
            ss_m_r   <= 1'b1;
            ss_s_r   <= 1'b1;
            mosi_m_r <= 1'b0;
            mosi_s_r <= 1'b0;
        end else begin
            sck_m_r  <= sck;
            sck_s_r  <= sck_m_r;
            sck_d_r  <= sck_s_r;
            ss_m_r   <= ss;
            ss_s_r   <= ss_m_r;
            mosi_m_r <= mosi;
            mosi_s_r <= mosi_m_r;
        end
    end

    // Frame state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; a deasserted select always returns to IDLE.
    always_comb begin
        state_nx_s = state_r;
        if (ss_s_r) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:  state_nx_s = ST_LOAD;
                ST_LOAD:  state_nx_s = ST_SHIFT;
                ST_SHIFT: state_nx_s = word_done_s ? ST_LOAD : ST_SHIFT;
                default:  state_nx_s = ST_IDLE;
            endcase
        end
    end

    // Serial datapath: load, transmit shift, receive shift and bit counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_r <= 5'd0;
            tx_sh_r   <= {WORD_LEN{1'b0}};
            rx_sh_r   <= {WORD_LEN{1'b0}};
            rx_buf_r  <= {WORD_LEN{1'b0}};
            miso_r    <= 1'b0;
        end else begin
            if (load_s) begin
                bit_cnt_r <= 5'd0;
                if (!cpha_s) begin
                    miso_r  <= out_bit(load_word_s, lsbfirst);
                    tx_sh_r <= out_shift(load_word_s, lsbfirst);
                end else begin
                    tx_sh_r <= load_word_s;
                end
            end else if (shift_s) begin
                miso_r  <= out_bit(tx_sh_r, lsbfirst);
                tx_sh_r <= out_shift(tx_sh_r, lsbfirst);
            end
            if (sample_s) begin
                rx_sh_r   <= rx_next_s;
                bit_cnt_r <= bit_cnt_r + 5'd1;
            end
            if (word_done_s) begin
                rx_buf_r <= rx_next_s;
            end
        end
    end

    // Host-side buffers and status flags; a set always beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_buf_r       <= {WORD_LEN{1'b0}};
            buffempty_r    <= 1'b1;
            charreceived_r <= 1'b0;
            senderr_r      <= 1'b0;
            overrun_r      <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                tx_buf_r    <= data;
                buffempty_r <= 1'b0;
            end else if (take_s) begin
                buffempty_r <= 1'b1;
            end
            if (wr_err_s) begin
                senderr_r <= 1'b1;
            end else if (res_senderr) begin
                senderr_r <= 1'b0;
            end
            if (word_done_s) begin
                charreceived_r <= 1'b1;
            end else if (rd) begin
                charreceived_r <= 1'b0;
            end
            if (word_done_s && charreceived_r && !rd) begin
                overrun_r <= 1'b1;
            end else if (res_overrun) begin
                overrun_r <= 1'b0;
            end
        end
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI peripheral-side interface; the counterpart of spi_master for board-to-board links and for loopback verification of spi_master.
- Oversamples sck/ss/mosi on the core clock, shifts one WORD_LEN-bit word per frame slot, drives miso.
- Host-side bus (data/wr/rd/buffempty/charreceived/senderr) matches spi_master so that host logic can be reused.

Parameters:
WORD_LEN, 8, bits per SPI word (2..16)

Ports:
clk  input  1  core clock; must be ≥ 8× sck frequency
rst  input  1  asynchronous active-low reset
data  inout  WORD_LEN  host bus; written on wr, driven with rx buffer while rd=1, else Z
wr  input  1  write data into tx buffer (sampled posedge clk)
rd  input  1  read rx buffer; clears charreceived
buffempty  output  1  tx buffer empty / may be written
charreceived  output  1  rx buffer holds an unread word
senderr  output  1  wr attempted while tx buffer full (sticky)
res_senderr  input  1  clear senderr
overrun  output  1  word completed while charreceived=1 (sticky)
res_overrun  input  1  clear overrun
lsbfirst  input  1  1 = LSB shifted first on both mosi and miso
mode  input  2  {CPOL,CPHA}
sck  input  1  SPI clock from master
mosi  input  1  SPI data in
miso  output  1  SPI data out; Z while ss=1
ss  input  1  active-low slave select

Behaviour:
- Reset (rst=0, async):
  - buffempty=1, charreceived=0, senderr=0, overrun=0, miso=Z.
  - Shift registers, bit counter and buffers cleared.
  - Synchronizer registers reset to ss=1, sck=CPOL.
- Synchronization:
  - sck, ss and mosi each pass through 2 flip-flops; edges are detected from the synchronized copies.
  - Resulting internal latency is 3 clk cycles; sck high and low phases must each be ≥ 4 clk.
- Edges:
  - Leading edge = sck leaving CPOL level; trailing edge = sck returning to CPOL.
  - CPHA=0: sample mosi on leading edge, shift miso on trailing edge.
  - CPHA=1: shift miso on leading edge, sample on trailing edge.
  - mode and lsbfirst must be stable while ss=0.
- States: IDLE (ss=1), LOAD, SHIFT.
  - IDLE: ss falling → LOAD.
  - LOAD (1 clk):
    - Tx shift register ← tx buffer if buffempty=0, then buffempty←1; otherwise tx shift register ← all ones.
    - Bit counter ← 0; → SHIFT.
    - For CPHA=0, the first bit is on miso at exit of LOAD.
  - SHIFT:
    - Each sample edge shifts mosi into the rx shift register and increments the counter.
    - When the counter reaches WORD_LEN:
      - rx buffer ← rx shift register; charreceived←1.
      - If charreceived was already 1: overrun←1 and the old word is overwritten.
      - → LOAD for the next word if ss is still 0.
  - ss rising in any state → IDLE, miso=Z.
    - A partial rx word is discarded and charreceived is unchanged.
    - A tx word already moved to the shift register is lost.
- Bit order:
  - lsbfirst=0: MSB first; mosi enters at bit0, miso from bit WORD_LEN-1.
  - lsbfirst=1: mirrored.
- Host write:
  - wr=1 at posedge with buffempty=1: tx buffer←data, buffempty←0 the next cycle.
  - wr=1 with buffempty=0: buffer unchanged, senderr←1.
  - wr coincident with a LOAD that empties the buffer: LOAD takes the old content first; the write then succeeds (buffempty ends 0).
- Host read:
  - data is driven combinationally from the rx buffer while rd=1.
  - charreceived clears at the posedge where rd=1, unless a new word completes in the same cycle; in that case charreceived stays 1 and overrun is not set.
- Flag clear priority: for senderr and overrun, set wins over simultaneous res_*.
- Transmit ordering: the tx buffer is a single entry. The host may write the next word once buffempty=1 (the previous word has been loaded), giving back-to-back words without gaps.

Test Plan:
- Mode 1, MSB-first, tx buffer=8'hA5, master sends 8'h55 → miso sequence 1,0,1,0,0,1,0,1; charreceived=1; rd returns 8'h55; buffempty=1 after LOAD.
- All 4 modes × lsbfirst, slave tx=8'h3C, master tx=8'hC3, loopback via spi_master → master reads 8'h3C, slave reads 8'hC3 in every combination.
- Two back-to-back words without reading: 8'h11 then 8'h22 → overrun=1, rd returns 8'h22; res_overrun clears overrun.
- Write 8'hAA, then write 8'h55 while buffempty=0 → senderr=1, the shifted word is 8'hAA; res_senderr=1 clears it.
- ss raised after 4 bits, then a new frame carrying 8'h0F → no charreceived from the partial frame; next word reads 8'h0F; empty buffer transmits 8'hFF.
- rst pulled low mid-word → all outputs at reset values immediately, miso=Z; next full frame transfers correctly.
